midi_param_tx: RTL and testbench



---
 rtl/midi_pkg.sv | 52 +++++
 rtl/uart_tx_byte.sv | 65 ++++++
 rtl/midi_param_tx.sv | 103 ++++++++++
 tb/tb_midi_param_tx.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared MIDI parameter definitions used by both the transmit block and the decoder.
// Holds the parameter index enum, note numbers and the index-to-message mapping helpers.
package midi_pkg;

    localparam logic [3:0] MIDI_NOTE_ON = 4'h9;
    localparam int         NUM_PARAMS   = 9;

    typedef enum logic [3:0] {
        MODE_A  = 4'd0,
        MODE_B  = 4'd1,
        ATTACK  = 4'd2,
        DECAY   = 4'd3,
        SUSTAIN = 4'd4,
        RELEASE = 4'd5,
        VOLUME  = 4'd6,
        DETUNE  = 4'd7,
        TEMPO   = 4'd8
    } param_idx_t;

    localparam logic [6:0] NOTE_MODE_A  = 7'd104;
    localparam logic [6:0] NOTE_MODE_B  = 7'd115;
    localparam logic [6:0] NOTE_ATTACK  = 7'd24;
    localparam logic [6:0] NOTE_DECAY   = 7'd25;
    localparam logic [6:0] NOTE_SUSTAIN = 7'd26;
    localparam logic [6:0] NOTE_RELEASE = 7'd27;
    localparam logic [6:0] NOTE_VOLUME  = 7'd28;
    localparam logic [6:0] NOTE_DETUNE  = 7'd22;
    localparam logic [6:0] NOTE_TEMPO   = 7'd21;

    function automatic logic [6:0] note_of(input logic [3:0] idx);
        logic [6:0] note;
        case (param_idx_t'(idx))
            MODE_A:  note = NOTE_MODE_A;
            MODE_B:  note = NOTE_MODE_B;
            ATTACK:  note = NOTE_ATTACK;
            DECAY:   note = NOTE_DECAY;
            SUSTAIN: note = NOTE_SUSTAIN;
            RELEASE: note = NOTE_RELEASE;
            VOLUME:  note = NOTE_VOLUME;
            DETUNE:  note = NOTE_DETUNE;
            TEMPO:   note = NOTE_TEMPO;
            default: note = 7'd0;
        endcase
        return note;
    endfunction

    // Receivers ignore velocity 0 on the mode selects, so those always go out at full velocity.
    function automatic logic [6:0] velocity_of(input logic [3:0] idx, input logic [6:0] value);
        return (idx == 4'(MODE_A) || idx == 4'(MODE_B)) ? 7'd127 : value;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte serialiser; a start on the same edge as done chains frames with no idle gap.
module uart_tx_byte #(
    parameter int BIT_CYC = 1600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam int CW = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 1;

    generate
        if (BIT_CYC < 2) begin : g_bit_cyc_check
            $error("uart_tx_byte: BIT_CYC must be at least 2");
        end
    endgenerate

    logic          r_tx;
    logic          r_active;
    logic [CW-1:0] r_cyc;
    logic [3:0]    r_bit;
    logic [7:0]    r_shift;
    logic          w_bit_end;

    assign w_bit_end = r_active && (r_cyc == CW'(BIT_CYC - 1));
    assign done      = w_bit_end && (r_bit == 4'd9);
    assign tx        = r_tx;

    // r_bit: 0 = start bit, 1..8 = data LSB first, 9 = stop bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tx     <= 1'b1;
            r_active <= 1'b0;
            r_cyc    <= '0;
            r_bit    <= 4'd0;
            r_shift  <= 8'd0;
        end else if (start) begin
            r_tx     <= 1'b0;
            r_active <= 1'b1;
            r_cyc    <= '0;
            r_bit    <= 4'd0;
            r_shift  <= data;
        end else if (w_bit_end) begin
            r_cyc <= '0;
            if (r_bit == 4'd9) begin
                r_active <= 1'b0;
                r_tx     <= 1'b1;
            end else begin
                r_bit <= r_bit + 4'd1;
                if (r_bit == 4'd8) begin
                    r_tx <= 1'b1;
                end else begin
                    r_tx    <= r_shift[0];
                    r_shift <= {1'b0, r_shift[7:1]};
                end
            end
        end else if (r_active) begin
            r_cyc <= r_cyc + 1'b1;
        end
    end

endmodule

// File: rtl/midi_param_tx.sv
// Parameter update to MIDI Note On transmitter: handshake, index mapping and 3-byte sequencing.
module midi_param_tx
    import midi_pkg::*;
#(
    parameter int         CLK_HZ  = 50_000_000,
    parameter int         BAUD    = 31_250,
    parameter logic [3:0] CHANNEL = 4'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_idx,
    input  logic [6:0] req_value,
    output logic       tx,
    output logic       busy,
    output logic       err
);

    localparam int         BIT_CYC = CLK_HZ / BAUD;
    localparam logic [7:0] STATUS  = {MIDI_NOTE_ON, CHANNEL};

    typedef enum logic {IDLE, SEND} state_t;

    state_t     r_state, w_state_next;
    logic [1:0] r_byte_cnt, w_byte_cnt_next;
    logic [6:0] r_note;
    logic [6:0] r_vel;
    logic       r_err;
    logic       r_live;
    logic       w_accept;
    logic       w_idx_ok;
    logic       w_start;
    logic [7:0] w_data;
    logic       w_done;

    assign req_ready = r_live && (r_state == IDLE);
    assign w_accept  = req_valid && req_ready;
    assign w_idx_ok  = (req_idx < 4'(NUM_PARAMS));
    assign busy      = (r_state != IDLE);
    assign err       = r_err;

    // The status byte is constant, so the first frame starts on the acceptance edge itself.
    always_comb begin
        w_state_next    = r_state;
        w_byte_cnt_next = r_byte_cnt;
        w_start         = 1'b0;
        w_data          = STATUS;
        case (r_state)
            IDLE: begin
                if (w_accept && w_idx_ok) begin
                    w_state_next    = SEND;
                    w_byte_cnt_next = 2'd0;
                    w_start         = 1'b1;
                end
            end
            SEND: begin
                if (w_done) begin
                    if (r_byte_cnt == 2'd2) begin
                        w_state_next = IDLE;
                    end else begin
                        w_byte_cnt_next = r_byte_cnt + 2'd1;
                        w_start         = 1'b1;
                        w_data          = (r_byte_cnt == 2'd0) ? {1'b0, r_note} : {1'b0, r_vel};
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_byte_cnt <= 2'd0;
            r_note     <= 7'd0;
            r_vel      <= 7'd0;
            r_err      <= 1'b0;
            r_live     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_byte_cnt <= w_byte_cnt_next;
            r_live     <= 1'b1;
            r_err      <= w_accept && !w_idx_ok;
            if (w_accept) begin
                r_note <= note_of(req_idx);
                r_vel  <= velocity_of(req_idx, req_value);
            end
        end
    end

    uart_tx_byte #(
        .BIT_CYC (BIT_CYC)
    ) u_uart (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_start),
        .data  (w_data),
        .tx    (tx),
        .done  (w_done)
    );

endmodule

// File: tb/tb_midi_param_tx.sv
// Bench for midi_param_tx: a bit-level line model predicts tx/busy/ready/err every cycle,
// with directed messages decoded off the line and compared against literal bytes.
module tb_midi_param_tx;

    localparam int B      = 4;
    localparam int CLK_HZ = 31_250 * B;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic [3:0] req_idx;
    logic [6:0] req_value;
    logic       ready0, tx0, busy0, err0;
    logic       ready5, tx5, busy5, err5;

    always #5 clk = ~clk;

    midi_param_tx #(.CLK_HZ(CLK_HZ), .BAUD(31_250), .CHANNEL(4'd0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready0),
        .req_idx(req_idx), .req_value(req_value), .tx(tx0), .busy(busy0), .err(err0)
    );

    midi_param_tx #(.CLK_HZ(CLK_HZ), .BAUD(31_250), .CHANNEL(4'd5)) dut5 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready5),
        .req_idx(req_idx), .req_value(req_value), .tx(tx5), .busy(busy5), .err(err5)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line model: each accepted message becomes 30*B expected line levels, one per cycle.
    int   notes [9] = '{104, 115, 24, 25, 26, 27, 28, 22, 21};
    bit   q0[$];
    bit   q5[$];
    bit   m_ready   = 1'b0;
    bit   m_err     = 1'b0;
    bit   m_started = 1'b0;
    int   n_txn     = 0;

    always @(posedge clk) begin
        bit         acc;
        bit         dummy;
        logic [7:0] b0 [3];
        logic [7:0] b5 [3];
        bit         v0, v5;
        if (!rst_n) begin
            q0.delete();
            q5.delete();
            m_ready   = 1'b0;
            m_err     = 1'b0;
            m_started = 1'b1;
        end else begin
            acc   = req_valid && m_ready;
            m_err = 1'b0;
            if (q0.size() > 0) begin
                dummy = q0.pop_front();
                dummy = q5.pop_front();
            end
            if (acc) begin
                n_txn++;
                if (req_idx < 9) begin
                    b0[0] = 8'h90;
                    b5[0] = 8'h95;
                    b0[1] = 8'(notes[req_idx]);
                    b0[2] = (req_idx < 2) ? 8'd127 : {1'b0, req_value};
                    b5[1] = b0[1];
                    b5[2] = b0[2];
                    for (int k = 0; k < 3; k++) begin
                        for (int i = 0; i < 10; i++) begin
                            v0 = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b0[k][i-1];
                            v5 = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b5[k][i-1];
                            for (int r = 0; r < B; r++) begin
                                q0.push_back(v0);
                                q5.push_back(v5);
                            end
                        end
                    end
                    $display("TXN %0d idx=%0d value=%0d -> %02h %02h %02h (ch0)",
                             n_txn, req_idx, req_value, b0[0], b0[1], b0[2]);
                end else begin
                    m_err = 1'b1;
                    $display("TXN %0d idx=%0d value=%0d -> rejected, err pulse", n_txn, req_idx, req_value);
                end
            end
            m_ready = (q0.size() == 0);
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("tx0",    tx0,    (q0.size() > 0) ? q0[0] : 1'b1);
            chk("tx5",    tx5,    (q5.size() > 0) ? q5[0] : 1'b1);
            chk("busy0",  busy0,  q0.size() > 0);
            chk("busy5",  busy5,  q5.size() > 0);
            chk("ready0", ready0, m_ready);
            chk("ready5", ready5, m_ready);
            chk("err0",   err0,   m_err);
            chk("err5",   err5,   m_err);
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (ready0 !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("wait_ready", ready0, 1'b1);
    endtask

    // Returns on the negedge right after the acceptance edge.
    task automatic issue(input int idx, input int val);
        wait_ready();
        req_valid = 1'b1;
        req_idx   = 4'(idx);
        req_value = 7'(val);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Samples mid-bit over one whole message; ends on the last negedge of the final stop bit.
    task automatic capture(input bit sel5, output logic [23:0] msg, output int busy_cnt);
        logic [29:0] bits;
        bits     = '0;
        busy_cnt = 0;
        for (int c = 0; c < 30 * B; c++) begin
            if ((sel5 ? busy5 : busy0) === 1'b1) busy_cnt++;
            if (c % B == B / 2) bits[c / B] = sel5 ? tx5 : tx0;
            if (c != 30 * B - 1) @(negedge clk);
        end
        msg = {bits[1 +: 8], bits[11 +: 8], bits[21 +: 8]};
    endtask

    initial begin
        logic [23:0] msg, msg2;
        int          bc;
        int          errs;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_idx   = 4'd0;
        req_value = 7'd0;
        repeat (3) @(negedge clk);
        chk("reset_tx", tx0, 1'b1);
        chk("reset_ready", ready0, 1'b0);
        chk("reset_busy", busy0, 1'b0);
        chk("reset_err", err0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", ready0, 1'b1);

        issue(2, 64);
        capture(1'b0, msg, bc);
        chk("msg_idx2", msg, 24'h901840);
        chk("busy_cycles_idx2", bc, 120);
        chk("ready_before_end", ready0, 1'b0);
        @(negedge clk);
        chk("ready_at_T121", ready0, 1'b1);

        issue(0, 0);
        capture(1'b0, msg, bc);
        chk("msg_idx0", msg, 24'h90687F);
        issue(1, 5);
        capture(1'b0, msg, bc);
        chk("msg_idx1", msg, 24'h90737F);
        issue(8, 0);
        capture(1'b1, msg, bc);
        chk("msg_idx8_ch5", msg, 24'h951500);

        issue(12, 33);
        errs = (err0 === 1'b1) ? 1 : 0;
        chk("invalid_tx", tx0, 1'b1);
        chk("invalid_busy", busy0, 1'b0);
        chk("invalid_ready", ready0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (err0 === 1'b1) errs++;
        end
        chk("invalid_err_cycles", errs, 1);

        wait_ready();
        req_valid = 1'b1;
        req_idx   = 4'd3;
        req_value = 7'd10;
        @(negedge clk);
        req_idx   = 4'd6;
        req_value = 7'd20;
        capture(1'b0, msg, bc);
        @(negedge clk);
        chk("b2b_gap_tx", tx0, 1'b1);
        chk("b2b_gap_ready", ready0, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        capture(1'b0, msg2, bc);
        chk("b2b_msg1", msg, 24'h90190A);
        chk("b2b_msg2", msg2, 24'h901C14);

        issue(5, 99);
        repeat (57) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_tx", tx0, 1'b1);
        chk("midreset_ready", ready0, 1'b0);
        chk("midreset_busy", busy0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        issue(7, 1);
        capture(1'b0, msg, bc);
        chk("after_reset_msg", msg, 24'h901601);

        for (int c = 0; c < 3000; c++) begin
            req_valid = ($urandom % 3) == 0;
            req_idx   = (($urandom % 6) == 0) ? 4'(9 + $urandom % 7) : 4'($urandom % 9);
            req_value = 7'($urandom % 128);
            @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (130) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
